// File: rtl/alu_seq_muldiv.sv
// Registered valid/ready execute ALU with optional iterative unsigned MUL/MULHU/DIVU/REMU.
// Define ALU_MULDIV_EN to build the shift-add multiplier and restoring divider.
module alu_seq_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [3:0]      alu_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] simple_res;
    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            start_iter;

    assign shamt = in2[SHW-1:0];

    always_comb begin
        simple_res = '0;
        case (alu_ctrl)
            4'b0000: simple_res = in1 & in2;
            4'b0001: simple_res = in1 | in2;
            4'b0010: simple_res = in1 + in2;
            4'b0110: simple_res = in1 - in2;
            4'b0011: simple_res = in1 ^ in2;
            4'b0111: simple_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            4'b1000: simple_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            4'b1001: simple_res = in1 << shamt;
            4'b1010: simple_res = in1 >> shamt;
            4'b1011: simple_res = XLEN'($signed(in1) >>> shamt);
            default: simple_res = '0;
        endcase
    end

    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign out_valid  = (state_q == DONE);
    assign alu_result = result_q;
    assign zero       = (result_q == '0);

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic              div_ok;

    assign start_iter = (alu_ctrl[3:2] == 2'b11);
    assign busy       = (state_q == BUSY);

    // acc holds {high, low} product for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_ok    = ~div_trial[XLEN];
        step      = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[1]) begin
            step = {(div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            opb_q <= '0;
            op_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opb_q <= opb_d;
            op_q  <= op_d;
        end
    end
`else
    assign start_iter = 1'b0;
    assign busy       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifdef ALU_MULDIV_EN
        cnt_d = cnt_q;
        acc_d = acc_q;
        opb_d = opb_q;
        op_d  = op_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (start_iter) begin
                        state_d = BUSY;
`ifdef ALU_MULDIV_EN
                        cnt_d = '0;
                        acc_d = {{XLEN{1'b0}}, in1};
                        opb_d = in2;
                        op_d  = alu_ctrl[1:0];
`endif
                    end else begin
                        state_d  = DONE;
                        result_d = simple_res;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
`ifdef ALU_MULDIV_EN
                acc_d = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d  = DONE;
                    result_d = op_q[0] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        // flush wins over everything, but the last result stays visible
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard testbench for alu_seq_muldiv; expectations follow ALU_MULDIV_EN when it is defined.
module tb_alu_seq_muldiv;
    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in1 = '0;
    logic [XLEN-1:0] in2 = '0;
    logic [3:0]      alu_ctrl = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            busy;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] lastRes = '0;

    alu_seq_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (c)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h3: return a ^ b;
            4'h7: return {31'b0, ($signed(a) < $signed(b))};
            4'h8: return {31'b0, (a < b)};
            4'h9: return a << b[4:0];
            4'hA: return a >> b[4:0];
            4'hB: return 32'($signed(a) >>> b[4:0]);
            4'hC: return MD ? p[31:0] : 32'h0;
            4'hD: return MD ? p[63:32] : 32'h0;
            4'hE: return !MD ? 32'h0 : (b == 0) ? 32'hFFFFFFFF : a / b;
            4'hF: return !MD ? 32'h0 : (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int modelLat(input logic [3:0] c);
        return (MD && c[3:2] == 2'b11) ? XLEN + 1 : 1;
    endfunction

    // Drive one op from a negedge, let it be accepted, then scramble the inputs
    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        in_valid = 1'b1;
        alu_ctrl = c;
        in1 = a;
        in2 = b;
        if (push) begin
            e.res = model(c, a, b);
            e.lat = modelLat(c);
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    task automatic waitValid(output int lat, output int busyCnt, output int readyCnt);
        lat = 1;
        busyCnt = 0;
        readyCnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busyCnt++;
            if (in_ready) readyCnt++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        nCompared++;
        if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nCompared++;
        if (alu_result !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_result: got %h expected 00000000", alu_result); end
        nCompared++;
        if (zero !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_zero: got %b expected 1", zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        exp_t e;
        int lat, bc, rc;
        out_ready = 1'b1;
        applyStimulus(4'h2, 32'h7FFFFFFF, 32'h1, 1'b1);
        waitValid(lat, bc, rc);
        e = sbq.pop_front();
        nCompared++;
        if (lat !== e.lat) begin nMismatched++; $display("[TB] FAIL add_latency: got %0d expected %0d", lat, e.lat); end
        nCompared++;
        if (alu_result !== e.res) begin nMismatched++; $display("[TB] FAIL add_result: got %h expected %h", alu_result, e.res); end
        nCompared++;
        if (zero !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_zero: got %b expected 0", zero); end
        lastRes = e.res;
        @(negedge clk);
        nCompared++;
        if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_retire: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  c[3];
        logic [31:0] a[3];
        logic [31:0] b[3];
        exp_t        e;
        c = '{4'h6, 4'h0, 4'h2};
        a = '{32'h5, 32'hF0, 32'h1};
        b = '{32'h5, 32'h0F, 32'h2};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            alu_ctrl = c[i];
            in1 = a[i];
            in2 = b[i];
            e.res = model(c[i], a[i], b[i]);
            e.lat = 1;
            sbq.push_back(e);
            nCompared++;
            if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_in_ready%0d: got %b expected 1", i, in_ready); end
            if (i > 0) begin
                e = sbq.pop_front();
                nCompared++;
                if (out_valid !== 1'b1 || alu_result !== e.res || zero !== (e.res == 0)) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_result%0d: got valid %b result %h zero %b expected 1 %h %b", i - 1, out_valid, alu_result, zero, e.res, (e.res == 0));
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        e = sbq.pop_front();
        nCompared++;
        if (out_valid !== 1'b1 || alu_result !== e.res) begin
            nMismatched++;
            $display("[TB] FAIL b2b_result2: got valid %b result %h expected 1 %h", out_valid, alu_result, e.res);
        end
        lastRes = e.res;
        @(negedge clk);
        nCompared++;
        if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_retire: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_simple_ops;
        exp_t        e;
        int          lat, bc, rc;
        logic [3:0]  c;
        logic [31:0] a, b;
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            c = 4'(k % 16);
            a = (k < 16) ? $urandom : 32'h80000000;
            b = (k < 16) ? $urandom : 32'hFFFFFFFF;
            applyStimulus(c, a, b, 1'b1);
            waitValid(lat, bc, rc);
            e = sbq.pop_front();
            nCompared++;
            if (lat !== e.lat) begin nMismatched++; $display("[TB] FAIL op%0h_latency: got %0d expected %0d", c, lat, e.lat); end
            nCompared++;
            if (alu_result !== e.res) begin nMismatched++; $display("[TB] FAIL op%0h_result: a %h b %h got %h expected %h", c, a, b, alu_result, e.res); end
            nCompared++;
            if (zero !== (e.res == 0)) begin nMismatched++; $display("[TB] FAIL op%0h_zero: got %b expected %b", c, zero, (e.res == 0)); end
            nCompared++;
            if (bc !== ((e.lat > 1) ? XLEN : 0)) begin nMismatched++; $display("[TB] FAIL op%0h_busy: got %0d cycles expected %0d", c, bc, (e.lat > 1) ? XLEN : 0); end
            lastRes = e.res;
            @(negedge clk);
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  c[8];
        logic [31:0] a[8];
        logic [31:0] b[8];
        exp_t        e;
        int          lat, bc, rc;
        c = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hE, 4'hF, 4'hC, 4'hE};
        a = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd9, 32'd9, 32'h12345678, 32'hFFFFFFFF};
        b = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd0, 32'd0, 32'h9ABCDEF0, 32'h80000001};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(c[i], a[i], b[i], 1'b1);
            waitValid(lat, bc, rc);
            e = sbq.pop_front();
            nCompared++;
            if (alu_result !== e.res) begin nMismatched++; $display("[TB] FAIL md%0d_result: got %h expected %h", i, alu_result, e.res); end
            nCompared++;
            if (lat !== e.lat) begin nMismatched++; $display("[TB] FAIL md%0d_latency: got %0d expected %0d", i, lat, e.lat); end
            nCompared++;
            if (bc !== (MD ? XLEN : 0)) begin nMismatched++; $display("[TB] FAIL md%0d_busy: got %0d cycles expected %0d", i, bc, MD ? XLEN : 0); end
            nCompared++;
            if (rc !== 0) begin nMismatched++; $display("[TB] FAIL md%0d_in_ready: got %0d ready cycles expected 0", i, rc); end
            lastRes = e.res;
            @(negedge clk);
        end
    endtask

    task automatic test_hold;
        exp_t e;
        int   lat, bc, rc;
        out_ready = 1'b0;
        applyStimulus(4'hB, 32'h80000000, 32'h4, 1'b1);
        waitValid(lat, bc, rc);
        e = sbq.pop_front();
        nCompared++;
        if (lat !== e.lat) begin nMismatched++; $display("[TB] FAIL hold_latency: got %0d expected %0d", lat, e.lat); end
        for (int h = 0; h < 5; h++) begin
            in_valid = 1'b1;
            alu_ctrl = 4'h2;
            in1 = 32'h1;
            in2 = 32'h1;
            nCompared++;
            if (alu_result !== e.res || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL hold_cycle%0d: got result %h ready %b valid %b expected %h 0 1", h, alu_result, in_ready, out_valid, e.res);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        nCompared++;
        if (out_valid !== 1'b0 || alu_result !== e.res) begin
            nMismatched++;
            $display("[TB] FAIL hold_release: got valid %b result %h expected 0 %h", out_valid, alu_result, e.res);
        end
        lastRes = e.res;
    endtask

    task automatic test_flush;
        logic [31:0] expRes;
        int          seen, bc, lat, rc;
        exp_t        e;
        out_ready = 1'b1;
        applyStimulus(4'hE, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        expRes = MD ? lastRes : model(4'hE, 32'd1000, 32'd3);
        nCompared++;
        if (busy !== MD) begin nMismatched++; $display("[TB] FAIL flush_pre_busy: got %b expected %b", busy, MD); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        nCompared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL flush_state: got valid %b ready %b busy %b expected 0 1 0", out_valid, in_ready, busy);
        end
        nCompared++;
        if (alu_result !== expRes) begin nMismatched++; $display("[TB] FAIL flush_result_kept: got %h expected %h", alu_result, expRes); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        nCompared++;
        if (seen !== 0) begin nMismatched++; $display("[TB] FAIL flush_no_output: got %0d valid cycles expected 0", seen); end

        in_valid = 1'b1;
        alu_ctrl = 4'h2;
        in1 = 32'd3;
        in2 = 32'd4;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        nCompared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || alu_result !== expRes) begin
            nMismatched++;
            $display("[TB] FAIL flush_accept_ignored: got valid %b busy %b result %h expected 0 0 %h", out_valid, busy, alu_result, expRes);
        end

        applyStimulus(4'h2, 32'd5, 32'd6, 1'b1);
        waitValid(lat, bc, rc);
        e = sbq.pop_front();
        nCompared++;
        if (alu_result !== e.res) begin nMismatched++; $display("[TB] FAIL pre_reset_add: got %h expected %h", alu_result, e.res); end
        @(negedge clk);

        // MUL still iterating (or held in DONE) when reset drops between edges
        out_ready = 1'b0;
        applyStimulus(4'hC, 32'd7, 32'd9, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nCompared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midop_reset_state: got valid %b busy %b ready %b expected 0 0 1", out_valid, busy, in_ready);
        end
        nCompared++;
        if (alu_result !== 32'h0 || zero !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midop_reset_result: got %h zero %b expected 00000000 1", alu_result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) seen++;
            @(negedge clk);
        end
        nCompared++;
        if (seen !== 0) begin nMismatched++; $display("[TB] FAIL reset_no_output: got %0d active cycles expected 0", seen); end

        applyStimulus(4'h2, 32'd2, 32'd2, 1'b1);
        waitValid(lat, bc, rc);
        e = sbq.pop_front();
        nCompared++;
        if (alu_result !== e.res || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_add: got %h lat %0d expected %h lat 1", alu_result, lat, e.res);
        end
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] alu_seq_muldiv bench, muldiv path %0s", MD ? "enabled" : "disabled");
        test_reset();
        test_add();
        test_back_to_back();
        test_simple_ops();
        test_muldiv();
        test_hold();
        test_flush();
        nCompared++;
        if (sbq.size() !== 0) begin nMismatched++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbq.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
